// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, issues one imem request at a time and queues responses for decode.
// Latency: grant in N, rvalid in N+1 -> inst_valid in N+2; a redirect re-fetches from its target the next cycle.
// Backpressure: a request is only raised while queue occupancy plus outstanding stays below DEPTH; decode stalls via inst_ready.
// Optional counters: define FETCH_SEQUENCER_PERF_EN to add the perf_fetched / perf_flushes outputs.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
`ifdef FETCH_SEQUENCER_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushes
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   req_addr_q, req_addr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   inst_mem_q [DEPTH];
  logic [31:0]   inst_mem_d [DEPTH];
  logic [31:0]   pc_mem_q   [DEPTH];
  logic [31:0]   pc_mem_d   [DEPTH];

  logic grant;
  logic push;
  logic pop;
  logic outstanding_after;

  // Handshake decode: only REQ with a free credit may request; responses after a redirect are dropped.
  always_comb begin
    imem_req          = (state_q == S_REQ) && (count_q < CW'(DEPTH));
    grant             = imem_req && imem_gnt;
    push              = (state_q == S_WAIT) && imem_rvalid && !redirect_en;
    pop               = inst_valid && inst_ready;
    outstanding_after = grant ||
                        (((state_q == S_WAIT) || (state_q == S_DRAIN)) && !imem_rvalid);
  end

  // Next state and PC; a redirect overrides everything, and goes to DRAIN if a response is still owed.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    case (state_q)
      S_IDLE:  state_d = S_REQ;
      S_REQ:   if (grant) state_d = S_WAIT;
      S_WAIT:  if (imem_rvalid) state_d = S_REQ;
      S_DRAIN: if (imem_rvalid) state_d = S_REQ;
      default: state_d = S_IDLE;
    endcase
    if (grant) begin
      pc_d       = pc_q + 32'd4;
      req_addr_d = pc_q;
    end
    if (redirect_en) begin
      state_d = outstanding_after ? S_DRAIN : S_REQ;
      pc_d    = redirect_pc & ~32'h3;
    end
  end

  // Instruction queue: circular buffer; a redirect empties it regardless of push/pop this cycle.
  always_comb begin
    inst_mem_d = inst_mem_q;
    pc_mem_d   = pc_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (redirect_en) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        inst_mem_d[wr_ptr_q] = imem_rdata;
        pc_mem_d[wr_ptr_q]   = req_addr_q;
        wr_ptr_d             = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // State, PC and queue registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inst_mem_q <= inst_mem_d;
      pc_mem_q   <= pc_mem_d;
    end
  end

  // Outputs come straight from registers; imem_addr is the live PC.
  always_comb begin
    imem_addr  = pc_q;
    inst_valid = (count_q != '0);
    inst       = inst_mem_q[rd_ptr_q];
    inst_pc    = pc_mem_q[rd_ptr_q];
  end

`ifdef FETCH_SEQUENCER_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_flushes_q, perf_flushes_d;

  // Event counters: instructions queued and redirect cycles, both free-running with wrap.
  always_comb begin
    perf_fetched_d = perf_fetched_q + (push ? 32'd1 : 32'd0);
    perf_flushes_d = perf_flushes_q + (redirect_en ? 32'd1 : 32'd0);
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_flushes_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_flushes_q <= perf_flushes_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushes = perf_flushes_q;
`endif

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Controller that sequences the instruction-fetch datapath: owns the program counter, issues one instruction-memory request at a time over a req/gnt handshake, and buffers returned instructions in a DEPTH-entry queue feeding decode over a valid/ready handshake. Branch and jalr redirects from execute flush the queue, discard any in-flight response and restart fetch at the new target. It sits between the execute stage, instruction memory and decode.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- DEPTH, 2, instruction queue entries (power of two, ≥2)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- redirect_en  in  1  branch taken / jalr redirect this cycle
- redirect_pc  in  32  redirect target
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address (word aligned)
- imem_gnt  in  1  request accepted this cycle (valid only while imem_req=1)
- imem_rvalid  in  1  response valid, earliest one cycle after grant
- imem_rdata  in  32  instruction word
- inst_valid  out  1  queue head valid
- inst  out  32  queue head instruction
- inst_pc  out  32  queue head PC
- inst_ready  in  1  decode accepts head

## Operation
- States: IDLE, REQ, WAIT, DRAIN. Reset → IDLE; IDLE → REQ after one cycle.
- REQ: imem_req=1, imem_addr=pc. Stay until imem_gnt. On grant: → WAIT, pc <= pc+4 (32-bit wrap, 32'hFFFF_FFFC+4 = 0).
- REQ asserted only when queue occupancy + outstanding < DEPTH; otherwise imem_req=0 and FSM holds in REQ.
- WAIT: on imem_rvalid push {imem_addr of that request, imem_rdata} to queue → REQ. At most one outstanding request.
- DRAIN: outstanding response is discarded; on imem_rvalid → REQ. Nothing pushed.
- Redirect (redirect_en=1), any state: queue flushed (occupancy 0, inst_valid 0 next cycle), pc <= redirect_pc.
  - Next state REQ, unless a request is outstanding after this cycle (state WAIT without rvalid this cycle, or REQ with imem_gnt this cycle) → DRAIN.
  - imem_rvalid in the redirect cycle: response dropped.
  - inst_ready && inst_valid in the redirect cycle: that handshake counts as completed; remaining entries flushed.
  - redirect_en in DRAIN: pc updated, stays in DRAIN.
- Queue: FIFO; simultaneous push and pop when full is allowed (pop frees the slot). Pop only when inst_valid && inst_ready.
- inst/inst_pc are stable while inst_valid=1 and inst_ready=0.
- Misaligned redirect_pc: low two bits forced to 0.

## Timing
- Reset values: imem_req 0, imem_addr RESET_PC, inst_valid 0, inst 0, inst_pc 0, counters 0; pc = RESET_PC.
- First imem_req: second rising edge after rst deasserts.
- Grant in cycle N, rvalid in N+1 → inst_valid=1 in N+2; next imem_req in N+2.
- Zero-wait memory throughput: one instruction per 2 cycles.
- Redirect in cycle N (no outstanding) → imem_req with imem_addr=redirect_pc in N+1.
- All outputs registered except imem_req (decoded from state and credit).

## Configuration
- FETCH_SEQUENCER_PERF_EN defined: adds outputs perf_fetched (32, increments per instruction pushed into queue) and perf_flushes (32, increments per redirect_en cycle); both reset to 0, wrap at 2^32.
- Not defined: ports and counters absent; functional behaviour identical.

## Test plan
- Reset with RESET_PC=32'h100, memory grant immediate, rvalid +1 cycle, inst_ready=1 → fetch addresses 0x100, 0x104, 0x108; inst_pc matches; one instruction every 2 cycles.
- inst_ready=0 held, DEPTH=2 → exactly two requests issued, imem_req stays 0 until one pop; head stays stable.
- Redirect to 0x200 while WAIT with rvalid 3 cycles later → late response discarded, next imem_addr=0x200, no stale instruction on inst.
- Redirect in same cycle as imem_gnt → FSM enters DRAIN, granted response dropped, then fetch from target.
- imem_gnt held low 5 cycles → imem_addr stable at same value throughout; asserting rst mid-WAIT → outputs return to reset values immediately.
- With FETCH_SEQUENCER_PERF_EN: 10 fetched instructions, 2 redirects → perf_fetched=10, perf_flushes=2.
